// File: rtl/i3c_pkg.sv
// Shared types and constants for the I3C target transaction interface.
// Holds the RX descriptor layout and the RX packer state encoding.
package i3c_pkg;

   localparam int unsigned TtiRxDescLenWidth  = 16;
   localparam int unsigned TtiRxDescLenOvfBit = 16;

   // RX descriptor as written into the TTI RX descriptor queue, MSB first
   typedef struct packed {
      logic        err;
      logic [13:0] reserved;
      logic        overflow;
      logic [15:0] len;
   } tti_rx_desc_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      FLUSH,
      DESC
   } tti_rx_packer_state_e;

endpackage

// File: rtl/tti_rx_packer.sv
// Byte-to-word packer and RX descriptor generator for the TTI RX path.
// Bytes of a private write are packed little-endian into 32-bit words; at
// the end of the transfer one descriptor with the byte count is written.
// Optional feature macro: TTI_RX_DESC_ERR_EN adds err_i and reports a
// sticky per-transfer error in descriptor bit 31.
module tti_rx_packer
   import i3c_pkg::*;
#(
   parameter int unsigned RxDataWidth     = 32,
   parameter int unsigned RxDescDataWidth = 32,
   parameter int unsigned LenWidth        = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       xfer_start_i,
   input  logic                       xfer_end_i,
   input  logic                       byte_valid_i,
   input  logic [7:0]                 byte_i,
   output logic                       byte_ready_o,
`ifdef TTI_RX_DESC_ERR_EN
   input  logic                       err_i,
`endif
   output logic                       rx_queue_wvalid_o,
   output logic [RxDataWidth-1:0]     rx_queue_wdata_o,
   input  logic                       rx_queue_wready_i,
   output logic                       rx_desc_queue_wvalid_o,
   output logic [RxDescDataWidth-1:0] rx_desc_queue_wdata_o,
   input  logic                       rx_desc_queue_wready_i,
   output logic                       busy_o
);

   tti_rx_packer_state_e state_q, state_d;

   logic [RxDataWidth-1:0]     word_q, word_d;
   logic [1:0]                 lane_q, lane_d;
   logic [LenWidth-1:0]        count_q, count_d;
   logic                       ovf_q, ovf_d;
   logic                       word_pending_q, word_pending_d;
   logic                       end_pending_q, end_pending_d;
   logic                       err_q, err_d;
   logic                       wvalid_d;
   logic                       desc_wvalid_d;
   logic [RxDescDataWidth-1:0] desc_data_d;
   logic                       load_desc;
   logic                       accept;
   logic                       word_hs;
   logic                       desc_hs;
   tti_rx_desc_t               desc_s;

   assign word_hs = rx_queue_wvalid_o & rx_queue_wready_i;
   assign desc_hs = rx_desc_queue_wvalid_o & rx_desc_queue_wready_i;

   // The data word register drives the queue directly, so the data output
   // is registered and holds still while a word waits for its handshake.
   assign rx_queue_wdata_o = word_q;

   // Ready depends only on state registers so there is no input-to-output path.
   assign byte_ready_o = (state_q == COLLECT) && !word_pending_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, packing and output decode; a byte arriving with the end
   // pulse is packed first, then the end decision sees the updated lane.
   always_comb begin
      state_d        = state_q;
      word_d         = word_q;
      lane_d         = lane_q;
      count_d        = count_q;
      ovf_d          = ovf_q;
      word_pending_d = word_pending_q;
      end_pending_d  = end_pending_q;
      err_d          = err_q;
      wvalid_d       = rx_queue_wvalid_o;
      desc_wvalid_d  = rx_desc_queue_wvalid_o;
      desc_data_d    = rx_desc_queue_wdata_o;
      load_desc      = 1'b0;
      accept         = 1'b0;

      case (state_q)
         IDLE: begin
            if (xfer_start_i) begin
               state_d        = COLLECT;
               word_d         = '0;
               lane_d         = '0;
               count_d        = '0;
               ovf_d          = 1'b0;
               word_pending_d = 1'b0;
               end_pending_d  = 1'b0;
               err_d          = 1'b0;
            end
         end

         COLLECT: begin
            accept = byte_valid_i && !word_pending_q;
            if (accept) begin
               word_d[8*lane_q +: 8] = byte_i;
               lane_d = lane_q + 2'd1;
               if (count_q == '1) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + LenWidth'(1);
               end
               if (lane_q == 2'd3) begin
                  word_pending_d = 1'b1;
                  wvalid_d       = 1'b1;
               end
            end
            if (word_hs) begin
               word_pending_d = 1'b0;
               wvalid_d       = 1'b0;
               word_d         = '0;
            end
`ifdef TTI_RX_DESC_ERR_EN
            if (err_i) begin
               err_d = 1'b1;
            end
`endif
            if (xfer_end_i) begin
               end_pending_d = 1'b1;
            end
            if (end_pending_d && !word_pending_d) begin
               if (lane_d != 2'd0) begin
                  state_d  = FLUSH;
                  wvalid_d = 1'b1;
               end else begin
                  state_d       = DESC;
                  desc_wvalid_d = 1'b1;
                  load_desc     = 1'b1;
               end
            end
         end

         FLUSH: begin
            if (word_hs) begin
               state_d       = DESC;
               wvalid_d      = 1'b0;
               word_d        = '0;
               desc_wvalid_d = 1'b1;
               load_desc     = 1'b1;
            end
         end

         DESC: begin
            if (desc_hs) begin
               state_d       = IDLE;
               desc_wvalid_d = 1'b0;
               desc_data_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      desc_s          = '0;
      desc_s.len      = TtiRxDescLenWidth'(count_d);
      desc_s.overflow = ovf_d;
      desc_s.err      = err_d;
      if (load_desc) begin
         desc_data_d = desc_s;
      end
   end

   // Datapath and registered outputs; reset drops any partial word and
   // any pending descriptor.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         word_q                 <= '0;
         lane_q                 <= '0;
         count_q                <= '0;
         ovf_q                  <= 1'b0;
         word_pending_q         <= 1'b0;
         end_pending_q          <= 1'b0;
         rx_queue_wvalid_o      <= 1'b0;
         rx_desc_queue_wvalid_o <= 1'b0;
         rx_desc_queue_wdata_o  <= '0;
         busy_o                 <= 1'b0;
      end else begin
         word_q                 <= word_d;
         lane_q                 <= lane_d;
         count_q                <= count_d;
         ovf_q                  <= ovf_d;
         word_pending_q         <= word_pending_d;
         end_pending_q          <= end_pending_d;
         rx_queue_wvalid_o      <= wvalid_d;
         rx_desc_queue_wvalid_o <= desc_wvalid_d;
         rx_desc_queue_wdata_o  <= desc_data_d;
         busy_o                 <= (state_d != IDLE);
      end
   end

`ifdef TTI_RX_DESC_ERR_EN
   // Sticky per-transfer bus error latch.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign err_q = 1'b0;
`endif

endmodule
